// File: rtl/alu_sequencer.sv
// Self-sequenced ALU with register file and flags: accepts one instruction per handshake,
// then runs read -> execute -> writeback on its own and retires with a done pulse.
module alu_sequencer #(
    parameter  int WIDTH     = 16,
    parameter  int REG_COUNT = 16,
    parameter  int IMM_WIDTH = 8,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [AW-1:0]        req_src,
    input  logic [AW-1:0]        req_dst,
    input  logic                 req_imm_en,
    input  logic [IMM_WIDTH-1:0] req_imm,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result,
    output logic                 carry,
    output logic                 low,
    output logic                 flag,
    output logic                 zero,
    output logic                 negative,
    input  logic [AW-1:0]        dbg_addr,
    output logic [WIDTH-1:0]     dbg_data
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_LSL  = 4'd8;
    localparam logic [3:0] OP_LSR  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                 state_q;
    logic                   ready_q, done_q, err_q;
    logic [3:0]             op_q;
    logic [AW-1:0]          src_q, dst_q;
    logic                   imm_en_q;
    logic [IMM_WIDTH-1:0]   imm_q;
    logic [WIDTH-1:0]       a_q, b_q;
    logic [WIDTH-1:0]       rf_q [REG_COUNT];
    logic [WIDTH-1:0]       res_q;
    logic                   c_q, l_q, f_q, z_q, n_q;
    logic [WIDTH-1:0]       ex_res_q, ex_res_d;
    logic                   ex_c_q, ex_l_q, ex_f_q, ex_z_q, ex_n_q;
    logic                   ex_c_d, ex_l_d, ex_f_d, ex_z_d, ex_n_d;
    logic                   ex_wr_q, ex_wr_d, ex_ill_q, ex_ill_d;

    logic [WIDTH-1:0]       imm_sext_s;
    logic                   cin_s;
    logic [WIDTH:0]         sum_s, diff_s;

    assign imm_sext_s = {{(WIDTH-IMM_WIDTH){imm_q[IMM_WIDTH-1]}}, imm_q};
    assign cin_s      = (op_q == OP_ADDC) ? c_q : 1'b0;
    assign sum_s      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_s};
    // diff_s[WIDTH] is the unsigned borrow, i.e. A < B
    assign diff_s     = {1'b0, a_q} - {1'b0, b_q};

    // ALU: next result and next flags; untouched flags default to their current value
    always_comb begin
        ex_res_d = res_q;
        ex_c_d   = c_q;
        ex_l_d   = l_q;
        ex_f_d   = f_q;
        ex_z_d   = z_q;
        ex_n_d   = n_q;
        ex_wr_d  = 1'b1;
        ex_ill_d = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDC: begin
                ex_res_d = sum_s[WIDTH-1:0];
                ex_c_d   = sum_s[WIDTH];
                ex_f_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_s[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                ex_res_d = diff_s[WIDTH-1:0];
                ex_c_d   = diff_s[WIDTH];
                ex_f_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_s[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_CMP: begin
                ex_res_d = diff_s[WIDTH-1:0];
                ex_wr_d  = 1'b0;
            end
            OP_AND:  ex_res_d = a_q & b_q;
            OP_OR:   ex_res_d = a_q | b_q;
            OP_XOR:  ex_res_d = a_q ^ b_q;
            OP_MOV:  ex_res_d = b_q;
            OP_LSL:  ex_res_d = a_q << b_q[SW-1:0];
            OP_LSR:  ex_res_d = a_q >> b_q[SW-1:0];
            default: begin
                ex_wr_d  = 1'b0;
                ex_ill_d = 1'b1;
            end
        endcase
        if (ex_wr_d) begin
            ex_z_d = (ex_res_d == {WIDTH{1'b0}});
            ex_n_d = ex_res_d[WIDTH-1];
        end else if (op_q == OP_CMP) begin
            ex_z_d = (a_q == b_q);
            ex_l_d = diff_s[WIDTH];
            ex_n_d = $signed(a_q) < $signed(b_q);
        end else begin
            ex_z_d = z_q;
            ex_n_d = n_q;
        end
    end

    // Control FSM with register file, operand/result pipeline and flags register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            op_q     <= 4'd0;
            src_q    <= '0;
            dst_q    <= '0;
            imm_en_q <= 1'b0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            {c_q, l_q, f_q, z_q, n_q} <= 5'b0;
            ex_res_q <= '0;
            {ex_c_q, ex_l_q, ex_f_q, ex_z_q, ex_n_q} <= 5'b0;
            ex_wr_q  <= 1'b0;
            ex_ill_q <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && ready_q) begin
                        op_q     <= req_op;
                        src_q    <= req_src;
                        dst_q    <= req_dst;
                        imm_en_q <= req_imm_en;
                        imm_q    <= req_imm;
                        ready_q  <= 1'b0;
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    a_q     <= rf_q[dst_q];
                    b_q     <= imm_en_q ? imm_sext_s : rf_q[src_q];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    ex_res_q <= ex_res_d;
                    {ex_c_q, ex_l_q, ex_f_q, ex_z_q, ex_n_q} <= {ex_c_d, ex_l_d, ex_f_d, ex_z_d, ex_n_d};
                    ex_wr_q  <= ex_wr_d;
                    ex_ill_q <= ex_ill_d;
                    state_q  <= S_WRITE;
                end
                S_WRITE: begin
                    if (ex_wr_q) begin
                        rf_q[dst_q] <= ex_res_q;
                    end
                    if (!ex_ill_q) begin
                        res_q <= ex_res_q;
                        {c_q, l_q, f_q, z_q, n_q} <= {ex_c_q, ex_l_q, ex_f_q, ex_z_q, ex_n_q};
                    end
                    done_q  <= 1'b1;
                    err_q   <= ex_ill_q;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = res_q;
    assign carry     = c_q;
    assign low       = l_q;
    assign flag      = f_q;
    assign zero      = z_q;
    assign negative  = n_q;
    assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: arithmetic reference model predicts each retirement,
// a monitor process checks every done pulse against the queued expectation.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [3:0]  req_src = 4'd0;
    logic [3:0]  req_dst = 4'd0;
    logic        req_imm_en = 1'b0;
    logic [7:0]  req_imm = 8'd0;
    logic        done, err;
    logic [15:0] result;
    logic        carry, low, flag, zero, negative;
    logic [3:0]  dbg_addr = 4'd0;
    logic [15:0] dbg_data;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .req_imm_en(req_imm_en),
        .req_imm(req_imm), .done(done), .err(err), .result(result), .carry(carry),
        .low(low), .flag(flag), .zero(zero), .negative(negative),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic c, l, f, z, n, e;
        int cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    // Reference model state
    int unsigned m_reg[16];
    int unsigned m_res;
    bit mC, mL, mF, mZ, mN;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int sgn(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        m_res = 0;
        {mC, mL, mF, mZ, mN} = 5'b0;
    endtask

    task automatic model_exec(input int op, input int src, input int dst, input bit ie,
                              input int unsigned imm, output exp_t e);
        int unsigned a, b, full, res, cin;
        int s;
        bit wr, ill;
        a = m_reg[dst];
        b = ie ? ((imm >= 128) ? imm + 32'hFF00 : imm) : m_reg[src];
        wr = 1'b1;
        ill = 1'b0;
        res = m_res;
        case (op)
            0, 1: begin
                cin  = (op == 1) ? 32'(mC) : 0;
                full = a + b + cin;
                res  = full & 32'hFFFF;
                mC   = full > 65535;
                s    = sgn(a) + sgn(b) + int'(cin);
                mF   = (s > 32767) || (s < -32768);
            end
            2: begin
                res = (a - b) & 32'hFFFF;
                mC  = a < b;
                s   = sgn(a) - sgn(b);
                mF  = (s > 32767) || (s < -32768);
            end
            3: begin
                res = (a - b) & 32'hFFFF;
                mZ  = a == b;
                mL  = a < b;
                mN  = sgn(a) < sgn(b);
                wr  = 1'b0;
            end
            4: res = a & b;
            5: res = a | b;
            6: res = a ^ b;
            7: res = b;
            8: res = (a << (b % 16)) & 32'hFFFF;
            9: res = a >> (b % 16);
            default: begin
                wr  = 1'b0;
                ill = 1'b1;
            end
        endcase
        if (!ill) begin
            m_res = res;
            if (op != 3) begin
                mZ = res == 0;
                mN = res >= 32768;
            end
        end
        if (wr) m_reg[dst] = res;
        e.res = m_res[15:0];
        e.c = mC; e.l = mL; e.f = mF; e.z = mZ; e.n = mN; e.e = ill;
        e.cyc = 0;
    endtask

    // Presents a request, waits (bounded) for acceptance, then queues the expected retirement
    task automatic issue(input int op, input int src, input int dst, input bit ie,
                         input int unsigned imm, output int acc);
        exp_t e;
        int n;
        @(negedge clk);
        req_op = op[3:0]; req_src = src[3:0]; req_dst = dst[3:0];
        req_imm_en = ie; req_imm = imm[7:0]; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        req_op = 4'($urandom); req_src = 4'($urandom); req_dst = 4'($urandom);
        req_imm_en = 1'($urandom); req_imm = 8'($urandom);
        model_exec(op, src, dst, ie, imm, e);
        e.cyc = acc + 3;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("retire_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic dbg_rd(input int addr, output logic [15:0] v);
        @(negedge clk);
        dbg_addr = addr[3:0];
        #1;
        v = dbg_data;
    endtask

    task automatic check_regs(input string nm);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            dbg_rd(i, v);
            chk(nm, {16'd0, v}, m_reg[i]);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("result", {16'd0, result}, {16'd0, e.res});
                chk("flags_CLFZN", {27'd0, carry, low, flag, zero, negative},
                    {27'd0, e.c, e.l, e.f, e.z, e.n});
                chk("err", {31'd0, err}, {31'd0, e.e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int a1, a2, op, n;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_flags", {27'd0, carry, low, flag, zero, negative}, 32'd0);
        chk("reset_result", {16'd0, result}, 32'd0);
        check_regs("reset_reg");

        // Sign extension of the immediate
        issue(7, 0, 1, 1'b1, 8'h7F, a1);
        issue(7, 0, 2, 1'b1, 8'h80, a1);
        wait_idle();
        dbg_rd(1, v); chk("mov_r1", {16'd0, v}, 32'h007F);
        dbg_rd(2, v); chk("mov_r2_sext", {16'd0, v}, 32'hFF80);
        chk("mov_neg", {31'd0, negative}, 32'd1);

        // Signed overflow, carry chain
        issue(7, 0, 1, 1'b1, 8'hFF, a1);
        issue(9, 0, 1, 1'b1, 8'h01, a1);
        issue(0, 1, 1, 1'b0, 8'h00, a1);
        wait_idle();
        dbg_rd(1, v); chk("add_r1", {16'd0, v}, 32'hFFFE);
        chk("add_FCN", {29'd0, flag, carry, negative}, 32'b101);
        issue(7, 0, 3, 1'b1, 8'hFF, a1);
        issue(1, 0, 3, 1'b1, 8'h01, a1);
        wait_idle();
        dbg_rd(3, v); chk("addc_r3", {16'd0, v}, 32'h0000);
        chk("addc_CZ", {30'd0, carry, zero}, 32'b11);
        issue(1, 0, 4, 1'b1, 8'h00, a1);
        wait_idle();
        dbg_rd(4, v); chk("addc_r4", {16'd0, v}, 32'h0001);

        // Compare: unsigned vs signed ordering, no writeback
        issue(7, 0, 5, 1'b1, 8'h01, a1);
        issue(7, 0, 6, 1'b1, 8'hFF, a1);
        issue(3, 6, 5, 1'b0, 8'h00, a1);
        wait_idle();
        chk("cmp1_LNZ", {29'd0, low, negative, zero}, 32'b100);
        dbg_rd(5, v); chk("cmp_r5", {16'd0, v}, 32'h0001);
        dbg_rd(6, v); chk("cmp_r6", {16'd0, v}, 32'hFFFF);
        issue(3, 5, 6, 1'b0, 8'h00, a1);
        wait_idle();
        chk("cmp2_LN", {30'd0, low, negative}, 32'b01);

        // Illegal opcode followed by a request held through the busy cycles
        issue(12, 2, 9, 1'b0, 8'h00, a1);
        issue(7, 0, 8, 1'b1, 8'h03, a2);
        chk("held_accept_gap", a2 - a1, 32'd4);
        wait_idle();
        check_regs("illegal_regs");

        // Reset while the MOV is in EXEC aborts it
        @(negedge clk);
        req_op = 4'd7; req_dst = 4'd7; req_imm_en = 1'b1; req_imm = 8'd5; req_valid = 1'b1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (6) @(negedge clk);
        dbg_rd(7, v); chk("abort_r7", {16'd0, v}, 32'h0000);
        chk("abort_flags", {27'd0, carry, low, flag, zero, negative}, 32'd0);

        // Shifts at the maximum amount
        issue(7, 0, 7, 1'b1, 8'h01, a1);
        issue(8, 0, 7, 1'b1, 8'd15, a1);
        wait_idle();
        dbg_rd(7, v); chk("lsl15", {16'd0, v}, 32'h8000);
        issue(9, 0, 7, 1'b1, 8'd15, a1);
        wait_idle();
        dbg_rd(7, v); chk("lsr15", {16'd0, v}, 32'h0001);

        // Randomized mix; seed registers with immediates first
        for (int i = 0; i < 16; i++) issue(7, 0, i, 1'b1, $urandom_range(0, 255), a1);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            issue(op, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
                  $urandom_range(0, 255), a1);
        end
        wait_idle();
        check_regs("random_regs");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Parametrised, self-sequenced successor to the hand-wired CPU datapath.
- Contains a REG_COUNT x WIDTH register file, an operand/result pipeline, a processor-status (flags) register and a control FSM.
- Accepts one ALU instruction per valid/ready handshake, then executes read -> execute -> writeback autonomously. No externally tied enables.
- Sits between a future instruction decoder and the board display/debug logic.

Parameters:
- WIDTH, 16, datapath and register width in bits (>=8).
- REG_COUNT, 16, number of registers; address width AW = clog2(REG_COUNT).
- IMM_WIDTH, 8, immediate field width; sign-extended to WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; clears FSM, register file, pipeline registers and flags.
- req_valid  input  1  instruction request valid.
- req_ready  output  1  high only in IDLE; a transfer occurs on a clk edge with req_valid && req_ready.
- req_op  input  4  operation code (see Behaviour).
- req_src  input  AW  source register address.
- req_dst  input  AW  destination register address (also operand A).
- req_imm_en  input  1  1: operand B = sign-extended req_imm; 0: operand B = reg[req_src].
- req_imm  input  IMM_WIDTH  immediate value.
- done  output  1  one-cycle pulse when an instruction retires.
- err  output  1  one-cycle pulse coincident with done for an illegal opcode.
- result  output  WIDTH  last retired ALU result; holds until next retire.
- carry, low, flag, zero, negative  output  1 each  flags register (C, L, F, Z, N).
- dbg_addr  input  AW  debug read address.
- dbg_data  output  WIDTH  combinational reg[dbg_addr].

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all registers=0, result=0, all flags=0, done=err=0, req_ready=1 on the cycle after reset deasserts. Reset in any state aborts the instruction; no writeback occurs.
- FSM: IDLE -> READ on accept. READ -> EXEC -> WRITE -> IDLE unconditionally.
- IDLE: req_ready=1. On accept, latch op, src, dst, imm_en and imm.
- READ: A = reg[dst]; B = imm_en ? sext(imm) : reg[src]; both registered.
- EXEC: compute result and next flags; both registered.
- WRITE: reg[dst] <= result unless op is CMP or illegal. Update flags, drive result, pulse done.
- Latency: request accepted at edge N; done high during cycle N+3; register write visible on dbg_data from N+4. Next accept no earlier than edge N+4 (throughput 1 op per 4 cycles).
- req_valid while busy is ignored; the requester must hold it. Request fields are don't-care outside the accept edge.
- Opcodes (results truncated to WIDTH):
  - 0 ADD: A+B.
  - 1 ADDC: A+B+C.
  - 2 SUB: A-B.
  - 3 CMP: no write.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 MOV: B.
  - 8 LSL: A << B[clog2(WIDTH)-1:0].
  - 9 LSR: logical right, same amount.
  - 10-15 illegal: no write, flags and result unchanged, err=1 with done.
- Flags:
  - Z and N come from result (N = result MSB) for all legal ops except CMP.
  - C: carry-out for ADD/ADDC; borrow (A<B unsigned) for SUB; unchanged otherwise.
  - F: signed overflow for ADD/ADDC/SUB; unchanged otherwise.
  - CMP: Z=(A==B), L=(A<B unsigned), N=(A<B signed); C and F unchanged. result is still updated to A-B.
  - L changes only on CMP.
- src==dst is legal: both operands read the same register.
- Back-to-back dependent ops see the prior writeback, because READ follows WRITE by at least one cycle.

Test Plan:
- Reset, then dbg_addr sweep 0..15 -> every dbg_data=0; all flags 0; req_ready=1.
- MOV r1 imm 0x7F; then MOV r2 imm 0x80 -> r1=0x007F; r2=0xFF80 (sign-extend); N=1 after the second op; done exactly 3 cycles after each accept.
- ADD r1,r1 with r1=0x7FFF -> r1=0xFFFE, F=1, C=0, N=1. Then ADDC with r3=0xFFFF, B=imm 1 -> r3=0x0000, C=1, Z=1. Then ADDC r4=0, imm 0 -> r4=1 using C=1.
- CMP r5=0x0001 vs r6=0xFFFF -> L=1, N=0, Z=0. r5 and r6 unchanged. Swap the operands -> L=0, N=1.
- Illegal op 12, then hold req_valid during busy cycles -> err and done pulse together; no register or flag change; the held request is accepted only when back in IDLE.
- Assert reset in the EXEC state of MOV r7 imm 5 -> r7 stays 0, no done pulse, FSM in IDLE the next cycle. LSL r7=1 by 15 -> 0x8000; LSR by 15 -> 0x0001.
